cc_miss_scheduler: RTL and testbench

- Sequences cache-miss servicing between the miss request FIFO and the memory AXI AR channel.
- Pops one miss address at a time and pushes the same address into the miss address FIFO for the data fill unit.
- Issues one critical-word-first WRAP burst per 64-byte line, and limits the number of in-flight bursts by counting R-channel last beats.
- Sits between the tag comparator's miss FIFOs and the memory AXI port; CC_CFG controls it through enable_i.

---
 rtl/cc_miss_scheduler.sv | 125 ++++++++++++
 tb/tb_cc_miss_scheduler.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_miss_scheduler.sv
// Cache-miss AR scheduler: pops miss addresses, forwards them to the fill unit,
// and issues one 8-beat WRAP burst per line while bounding in-flight bursts.
module cc_miss_scheduler #(
  parameter int          MAX_OUTSTANDING = 4,
  parameter logic [3:0]  AR_ID           = 4'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_i,
  input  logic        miss_req_fifo_empty_i,
  input  logic [31:0] miss_req_fifo_rdata_i,
  output logic        miss_req_fifo_rden_o,
  input  logic        miss_addr_fifo_full_i,
  output logic        miss_addr_fifo_wren_o,
  output logic [31:0] miss_addr_fifo_wdata_o,
  output logic [3:0]  mem_arid_o,
  output logic [31:0] mem_araddr_o,
  output logic [3:0]  mem_arlen_o,
  output logic [2:0]  mem_arsize_o,
  output logic [1:0]  mem_arburst_o,
  output logic        mem_arvalid_o,
  input  logic        mem_arready_i,
  input  logic        mem_rvalid_i,
  input  logic        mem_rready_i,
  input  logic        mem_rlast_i,
  output logic [3:0]  outstanding_o,
  output logic [15:0] issue_cnt_o,
  output logic        err_o
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] araddr_reg;
  logic [3:0]  outstanding_reg;
  logic [15:0] issue_cnt_reg;
  logic        err_reg;

  logic        in_issue;
  logic        ar_hs;
  logic        r_last;
  logic [4:0]  outstanding_next_cap;
  logic        can_pop;
  logic        pop;
  logic [31:0] line_addr;
  logic        unused_low;

  // Critical word is kept: only the byte-in-word offset is cleared.
  assign line_addr  = {miss_req_fifo_rdata_i[31:3], 3'b000};
  assign unused_low = ^miss_req_fifo_rdata_i[2:0];

  assign in_issue = (state_reg == ISSUE);
  assign ar_hs    = in_issue & mem_arready_i;
  assign r_last   = mem_rvalid_i & mem_rready_i & mem_rlast_i;

  // The burst sitting in ISSUE already counts against the limit.
  assign outstanding_next_cap = {1'b0, outstanding_reg} + {4'd0, in_issue};
  assign can_pop = enable_i & ~miss_req_fifo_empty_i & ~miss_addr_fifo_full_i &
                   (outstanding_next_cap < 5'(MAX_OUTSTANDING));

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (can_pop) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_arready_i) begin
          if (can_pop) begin
            pop = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      araddr_reg      <= 32'd0;
      outstanding_reg <= 4'd0;
      issue_cnt_reg   <= 16'd0;
      err_reg         <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (pop) begin
        araddr_reg <= line_addr;
      end
      if (ar_hs) begin
        issue_cnt_reg <= issue_cnt_reg + 16'd1;
      end
      if (r_last && outstanding_reg == 4'd0) begin
        err_reg <= 1'b1;
      end
      if (ar_hs && !r_last) begin
        outstanding_reg <= outstanding_reg + 4'd1;
      end else if (!ar_hs && r_last && outstanding_reg != 4'd0) begin
        outstanding_reg <= outstanding_reg - 4'd1;
      end
    end
  end

  // The pushed address must be valid in the push cycle, so it follows the FIFO head.
  assign miss_req_fifo_rden_o   = pop;
  assign miss_addr_fifo_wren_o  = pop;
  assign miss_addr_fifo_wdata_o = line_addr;

  assign mem_arid_o    = AR_ID;
  assign mem_araddr_o  = araddr_reg;
  assign mem_arlen_o   = 4'd7;
  assign mem_arsize_o  = 3'd3;
  assign mem_arburst_o = 2'b10;
  assign mem_arvalid_o = in_issue;
  assign outstanding_o = outstanding_reg;
  assign issue_cnt_o   = issue_cnt_reg;
  assign err_o         = err_reg;

endmodule

// File: tb/tb_cc_miss_scheduler.sv
// Bench for cc_miss_scheduler: queue-based miss FIFO and AR scoreboard, checked
// every cycle, driven by directed scenarios followed by a randomized phase.
module tb_cc_miss_scheduler;

  localparam int MAXO = 4;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        req_empty;
  logic [31:0] req_rdata;
  logic        rden;
  logic        full;
  logic        wren;
  logic [31:0] wdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic        rvalid;
  logic        rready;
  logic        rlast;
  logic [3:0]  outstanding;
  logic [15:0] issue_cnt;
  logic        err;

  cc_miss_scheduler #(.MAX_OUTSTANDING(MAXO), .AR_ID(4'd0)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .enable_i               (en),
    .miss_req_fifo_empty_i  (req_empty),
    .miss_req_fifo_rdata_i  (req_rdata),
    .miss_req_fifo_rden_o   (rden),
    .miss_addr_fifo_full_i  (full),
    .miss_addr_fifo_wren_o  (wren),
    .miss_addr_fifo_wdata_o (wdata),
    .mem_arid_o             (arid),
    .mem_araddr_o           (araddr),
    .mem_arlen_o            (arlen),
    .mem_arsize_o           (arsize),
    .mem_arburst_o          (arburst),
    .mem_arvalid_o          (arvalid),
    .mem_arready_i          (arready),
    .mem_rvalid_i           (rvalid),
    .mem_rready_i           (rready),
    .mem_rlast_i            (rlast),
    .outstanding_o          (outstanding),
    .issue_cnt_o            (issue_cnt),
    .err_o                  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] req_q[$];   // miss request FIFO contents
  logic [31:0] ar_q[$];    // popped line addresses whose AR has not handshaken
  int          out_m = 0;
  logic [15:0] cnt_m = 16'd0;
  logic        err_m = 1'b0;
  logic [15:0] base_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic update_fifo();
    req_empty = (req_q.size() == 0);
    req_rdata = (req_q.size() == 0) ? 32'd0 : req_q[0];
  endtask

  task automatic push_miss(input logic [31:0] a);
    req_q.push_back(a);
    update_fifo();
  endtask

  // One clock: check every output against the model, then advance the model.
  task automatic cycle();
    logic        pend, hs, rl, exp_pop;
    logic [31:0] head;
    @(negedge clk);
    pend = (ar_q.size() != 0);
    hs   = pend & arready;
    rl   = rvalid & rready & rlast;
    head = (req_q.size() != 0) ? req_q[0] : 32'd0;
    exp_pop = en && (req_q.size() != 0) && !full &&
              ((out_m + (pend ? 1 : 0)) < MAXO) && (!pend || arready);
    chk("rden", 32'(rden), 32'(exp_pop));
    chk("wren", 32'(wren), 32'(exp_pop));
    if (exp_pop) chk("wdata", wdata, {head[31:3], 3'b000});
    chk("arvalid", 32'(arvalid), 32'(pend));
    if (pend) chk("araddr", araddr, ar_q[0]);
    chk("outstanding", 32'(outstanding), 32'(out_m));
    chk("issue_cnt", 32'(issue_cnt), 32'(cnt_m));
    chk("err", 32'(err), 32'(err_m));
    chk("limit", 32'(outstanding <= 4'(MAXO)), 32'd1);
    if (hs) begin
      void'(ar_q.pop_front());
      cnt_m = cnt_m + 16'd1;
    end
    if (rl && out_m == 0) err_m = 1'b1;
    if (hs && !rl) out_m++;
    else if (!hs && rl && out_m > 0) out_m--;
    if (exp_pop) begin
      ar_q.push_back({head[31:3], 3'b000});
      void'(req_q.pop_front());
    end
    @(posedge clk);
    #1;
    update_fifo();
  endtask

  task automatic rbeat(input logic last);
    rvalid = 1'b1; rready = 1'b1; rlast = last;
    cycle();
    rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
  endtask

  // Let queued misses issue, then retire every burst with one rlast beat each.
  task automatic drain();
    arready = 1'b1;
    for (int i = 0; i < 64 && (out_m > 0 || ar_q.size() != 0 || req_q.size() != 0); i++) begin
      if (out_m > 0) rbeat(1'b1);
      else cycle();
    end
    chk("drained", 32'(outstanding), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; full = 1'b0; arready = 1'b0;
    rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
    update_fifo();
    #1;
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_issue_cnt", 32'(issue_cnt), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("arid", 32'(arid), 32'd0);
    chk("arlen", 32'(arlen), 32'd7);
    chk("arsize", 32'(arsize), 32'd3);
    chk("arburst", 32'(arburst), 32'd2);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    en = 1'b1;

    // Single miss, then 8 beats with rlast on the last one.
    arready = 1'b1;
    push_miss(32'h1234_5678);
    cycle();
    cycle();
    chk("single_outstanding", 32'(outstanding), 32'd1);
    for (int i = 0; i < 8; i++) rbeat(i == 7);
    chk("single_done_out", 32'(outstanding), 32'd0);
    chk("single_done_cnt", 32'(issue_cnt), 32'd1);

    // AR backpressure for 5 cycles with a second miss waiting.
    arready = 1'b0;
    push_miss(32'hABCD_0047);
    push_miss(32'h0000_1FC8);
    cycle();
    repeat (5) cycle();
    arready = 1'b1;
    cycle();
    chk("bp_cnt", 32'(issue_cnt), 32'd2);
    drain();

    // Outstanding limit with idle R channel.
    base_cnt = cnt_m;
    for (int i = 0; i < 6; i++) push_miss(32'h4000_0000 + 32'(i * 64 + 8));
    repeat (8) cycle();
    chk("limit_out", 32'(outstanding), 32'd4);
    chk("limit_cnt", 32'(issue_cnt), 32'(base_cnt + 16'd4));
    rbeat(1'b1);
    repeat (3) cycle();
    chk("limit_5th", 32'(issue_cnt), 32'(base_cnt + 16'd5));
    drain();

    // Back-to-back bursts.
    base_cnt = cnt_m;
    push_miss(32'h1000_0010);
    push_miss(32'h2000_0020);
    push_miss(32'h3000_0030);
    repeat (5) cycle();
    chk("b2b_cnt", 32'(issue_cnt), 32'(base_cnt + 16'd3));
    drain();

    // Handshake and rlast together with two bursts in flight.
    push_miss(32'h5555_0000);
    push_miss(32'h6666_0000);
    repeat (4) cycle();
    chk("sim_pre", 32'(outstanding), 32'd2);
    arready = 1'b0;
    push_miss(32'h7777_0000);
    cycle();
    cycle();
    arready = 1'b1; rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
    cycle();
    rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
    chk("sim_out", 32'(outstanding), 32'd2);
    drain();

    // Miss address FIFO full blocks popping.
    full = 1'b1;
    push_miss(32'h8888_0000);
    repeat (5) cycle();
    full = 1'b0;
    drain();

    // Enable drops while an AR is pending.
    arready = 1'b0;
    push_miss(32'h9999_0000);
    push_miss(32'hAAAA_0000);
    cycle();
    en = 1'b0;
    repeat (3) cycle();
    arready = 1'b1;
    repeat (3) cycle();
    en = 1'b1;
    drain();

    // rlast with nothing outstanding sets the sticky error.
    rbeat(1'b1);
    repeat (3) cycle();
    chk("err_sticky", 32'(err), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      arready = ($urandom_range(0, 3) != 0);
      en      = ($urandom_range(0, 15) != 0);
      full    = ($urandom_range(0, 7) == 0);
      if (req_q.size() < 6 && $urandom_range(0, 1) == 1) push_miss($urandom);
      rvalid  = ($urandom_range(0, 1) == 1);
      rready  = ($urandom_range(0, 1) == 1);
      rlast   = (out_m > 0) && ($urandom_range(0, 2) == 0);
      cycle();
    end
    rvalid = 1'b0; rready = 1'b0; rlast = 1'b0; en = 1'b1; full = 1'b0;
    drain();

    // Asynchronous reset while an AR is pending.
    arready = 1'b0;
    push_miss(32'hDEAD_BEE8);
    cycle();
    cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_arvalid", 32'(arvalid), 32'd0);
    chk("arst_out", 32'(outstanding), 32'd0);
    chk("arst_cnt", 32'(issue_cnt), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    req_q.delete();
    ar_q.delete();
    out_m = 0; cnt_m = 16'd0; err_m = 1'b0;
    update_fifo();
    @(posedge clk);
    #1 rst_n = 1'b1;
    arready = 1'b1;
    push_miss(32'h0BAD_CAF8);
    repeat (3) cycle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
